// File: rtl/sigmoid_pkg.sv
// Shared definitions for the Sigmoid forward/backward blocks: default widths,
// fixed-point helpers and the activation/gradient types.
package sigmoid_pkg;

  localparam int DEF_IN_WIDTH  = 15;
  localparam int DEF_OUT_WIDTH = 11;

  // Fixed-point 1.0 for an activation of the given width.
  function automatic int act_one(input int out_width);
    return 1 << (out_width - 1);
  endfunction

  // Fraction bits of a*(ONE-a); shifting by this returns to gradient scale.
  function automatic int frac_shift(input int out_width);
    return 2 * (out_width - 1);
  endfunction

  typedef logic        [DEF_OUT_WIDTH-1:0] act_t;
  typedef logic signed [DEF_IN_WIDTH-1:0]  grad_t;

endpackage

// File: rtl/sigmoid_bwd_stage.sv
// Generic registered pipeline stage: a valid bit plus payload, both loaded
// only when the whole pipeline advances.
module sigmoid_bwd_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Capture the upstream slot (valid or bubble) on advance, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (adv_i) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/sigmoid_backward.sv
// Sigmoid backward pass: out_grad = round(g * a * (ONE - a) / 2**SH),
// three-stage pipeline with a single shared advance enable.
module sigmoid_backward
  import sigmoid_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic        [OUT_WIDTH-1:0] in_act,
  input  logic signed [IN_WIDTH-1:0]  in_grad,
  input  logic                        in_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [IN_WIDTH-1:0]  out_grad,
  output logic                        busy
);

  localparam int ONE   = act_one(OUT_WIDTH);
  localparam int SH    = frac_shift(OUT_WIDTH);
  localparam int D_W   = SH - 1;               // a*(ONE-a) peaks at ONE*ONE/4
  localparam int P_W   = IN_WIDTH + SH;
  localparam int S1_W  = 1 + IN_WIDTH + D_W;   // {mask, g, d}
  localparam int ROUND = 1 << (SH - 1);

  // Handshake: a transfer happens on an edge where valid & ready are both 1.
  // The whole pipe moves when the output slot is empty or being taken
  // (adv = ~out_valid | out_ready); in_ready is that same advance, so a full
  // pipe with a stalled consumer refuses input and nothing is overwritten.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  logic [OUT_WIDTH-1:0] one_minus_a_d;
  logic [D_W-1:0]       deriv_d;
  logic [S1_W-1:0]      s1_d, s1_q;
  logic                 s1_valid;

  logic                       s1_mask;
  logic signed [IN_WIDTH-1:0] s1_g;
  logic [D_W-1:0]             s1_deriv;

  logic signed [P_W-1:0] p_d, p_q;
  logic                  s2_valid;

  logic [IN_WIDTH-1:0] r_d;

  // Stage 1 input: sigmoid derivative a*(ONE-a); a=ONE-1 gives ONE-1.
  always_comb begin
    one_minus_a_d = OUT_WIDTH'(ONE) - in_act;
    deriv_d       = D_W'(in_act) * D_W'(one_minus_a_d);
    s1_d          = {~in_en, in_grad, deriv_d};
  end

  sigmoid_bwd_stage #(.W(S1_W)) u_s1 (
    .clk(clk), .rst_n(rst_n), .adv_i(adv),
    .valid_i(in_valid), .data_i(s1_d),
    .valid_o(s1_valid), .data_o(s1_q)
  );

  assign {s1_mask, s1_g, s1_deriv} = s1_q;

  // Stage 2 input: full-precision signed product, zeroed for masked entries.
  always_comb begin
    p_d = '0;
    if (!s1_mask) begin
      p_d = P_W'(s1_g) * P_W'($signed({1'b0, s1_deriv}));
    end
  end

  sigmoid_bwd_stage #(.W(P_W)) u_s2 (
    .clk(clk), .rst_n(rst_n), .adv_i(adv),
    .valid_i(s1_valid), .data_i(p_d),
    .valid_o(s2_valid), .data_o(p_q)
  );

  // Stage 3 input: round half up, arithmetic shift; |result| <= |g|/4 so the
  // truncation to IN_WIDTH never loses magnitude.
  always_comb begin
    r_d = IN_WIDTH'((p_q + P_W'(ROUND)) >>> SH);
  end

  sigmoid_bwd_stage #(.W(IN_WIDTH)) u_s3 (
    .clk(clk), .rst_n(rst_n), .adv_i(adv),
    .valid_i(s2_valid), .data_i(r_d),
    .valid_o(out_valid), .data_o(out_grad)
  );

  assign busy = s1_valid | s2_valid | out_valid;

endmodule

// File: tb/tb_sigmoid_backward.sv
// Bench for sigmoid_backward: behavioural reference, per-cycle scoreboard,
// directed literal cases and a randomized stream with random backpressure.
module tb_sigmoid_backward;

  localparam int IW = 15;
  localparam int OW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] in_act;
  logic [IW-1:0] in_grad;
  logic          in_en;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_grad;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_in   = 0;
  int n_out  = 0;
  bit strict_lat = 1'b0;
  bit rand_ready = 1'b0;
  bit front_seen = 1'b0;

  logic [IW-1:0] exp_q[$];
  int            age_q[$];
  logic [IW-1:0] got_q[$];

  sigmoid_backward #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_grad(in_grad), .in_en(in_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_grad(out_grad), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int sgn(input logic [IW-1:0] v);
    return int'($signed(v));
  endfunction

  // Reference: g * a*(1024-a) / 2^20, rounded half up (floor of x + 1/2).
  function automatic logic [IW-1:0] ref_grad(input int a, input int g, input bit en);
    longint d, p, q, r;
    if (!en) return '0;
    d = longint'(a) * longint'(1024 - a);
    p = longint'(g) * d;
    q = p + 524288;
    if (q >= 0) r = q / 1048576;
    else        r = -((-q + 1048575) / 1048576);
    return r[IW-1:0];
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      age_q.delete();
      front_seen = 1'b0;
    end else begin
      chk("in_ready", int'(in_ready), int'(!out_valid || out_ready));
      chk("busy", int'(busy), int'(exp_q.size() != 0));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          chk("out_grad", sgn(out_grad), sgn(exp_q[0]));
          if (!front_seen) begin
            front_seen = 1'b1;
            if (strict_lat) chk("latency", cyc - age_q[0], 3);
            else            chk("latency_min", int'((cyc - age_q[0]) >= 3), 1);
          end
          if (out_ready) begin
            got_q.push_back(out_grad);
            void'(exp_q.pop_front());
            void'(age_q.pop_front());
            front_seen = 1'b0;
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_grad(int'(in_act), sgn(in_grad), in_en));
        age_q.push_back(cyc);
        n_in++;
      end
    end
  end

  // Random backpressure source.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int a, input int g, input bit en, output int stalls);
    stalls   = 0;
    in_valid = 1'b1;
    in_act   = OW'(a);
    in_grad  = IW'(g);
    in_en    = en;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      stalls++;
      if (stalls > 200) begin
        chk("send_timeout", stalls, 0);
        break;
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", int'(exp_q.size()), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int va[6];
    int vg[6];
    int ve[6];
    int st, j, held, n0, a, g;
    bit have, en;

    va = '{512, 511, 0, 1023, 512, 512};
    vg = '{1000, 1000, 1000, 16383, -1000, -16384};
    ve = '{250, 250, 0, 16, -250, -4096};

    rst_n = 1'b0; in_valid = 1'b0; in_act = '0; in_grad = '0;
    in_en = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_grad", sgn(out_grad), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Model pins against hand-computed values.
    chk("model_511", sgn(ref_grad(511, 1000, 1)), 250);
    chk("model_1023", sgn(ref_grad(1023, 16383, 1)), 16);
    chk("model_neg", sgn(ref_grad(512, -16384, 1)), -4096);

    // Basic values, exact latency 3.
    got_q.delete(); strict_lat = 1'b1;
    for (int i = 0; i < 6; i++) send(va[i], vg[i], 1'b1, st);
    drain();
    chk("basic_count", int'(got_q.size()), 6);
    for (int i = 0; i < 6; i++)
      if (i < got_q.size()) chk("basic_value", sgn(got_q[i]), ve[i]);

    // Streaming: 8 back-to-back, never stalled.
    got_q.delete();
    for (int k = 1; k <= 8; k++) begin
      send(512, 4 * k, 1'b1, st);
      chk("stream_in_ready", st, 0);
    end
    drain();
    chk("stream_count", int'(got_q.size()), 8);
    for (int k = 0; k < 8; k++)
      if (k < got_q.size()) chk("stream_value", sgn(got_q[k]), k + 1);

    // Backpressure: out_ready low for 5 cycles while 4 inputs are offered.
    got_q.delete(); strict_lat = 1'b0;
    out_ready = 1'b0; j = 0; have = 1'b0; held = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_act = OW'(512); in_grad = IW'(40 * (j + 1)); in_en = 1'b1;
      @(negedge clk);
      if (out_valid) begin
        if (!have) begin
          held = sgn(out_grad);
          have = 1'b1;
        end else begin
          chk("stall_stable", sgn(out_grad), held);
        end
      end
      if (c == 4) chk("bp_in_ready", int'(in_ready), 0);
      if (in_ready) j++;
      @(posedge clk);
      #1;
    end
    chk("bp_accepted", j, 3);
    out_ready = 1'b1;
    for (int k = j; k < 4; k++) send(512, 40 * (k + 1), 1'b1, st);
    drain();
    chk("bp_count", int'(got_q.size()), 4);
    for (int k = 0; k < 4; k++)
      if (k < got_q.size()) chk("bp_value", sgn(got_q[k]), 10 * (k + 1));

    // Enable masking.
    got_q.delete(); strict_lat = 1'b1;
    send(512, 1000, 1'b0, st);
    send(512, 1000, 1'b1, st);
    drain();
    chk("mask_count", int'(got_q.size()), 2);
    if (got_q.size() == 2) begin
      chk("mask_zero", sgn(got_q[0]), 0);
      chk("mask_next", sgn(got_q[1]), 250);
    end

    // Randomized stream with random backpressure.
    strict_lat = 1'b0; rand_ready = 1'b1; n0 = n_in;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) idle();
      if ($urandom_range(0, 9) == 0) a = ($urandom_range(0, 1) == 1) ? 1023 : 0;
      else                           a = int'($urandom_range(0, 1023));
      g  = sgn(IW'($urandom_range(0, 32767)));
      en = ($urandom_range(0, 9) != 0);
      send(a, g, en, st);
    end
    in_valid = 1'b0; rand_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    chk("rand_in_count", n_in - n0, 1000);
    chk("in_eq_out", n_in, n_out);

    // Asynchronous reset with two transactions in flight.
    got_q.delete(); strict_lat = 1'b1;
    send(300, 5000, 1'b1, st);
    send(700, -3000, 1'b1, st);
    in_valid = 1'b0;
    #2;
    chk("busy_before_rst", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_out_grad", sgn(out_grad), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_out_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
    end
    send(512, 1000, 1'b1, st);
    drain();
    chk("post_rst_count", int'(got_q.size()), 1);
    if (got_q.size() == 1) chk("post_rst_value", sgn(got_q[0]), 250);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
